// File: rtl/text_entry_ctrl.sv
// Keyboard-to-message sequencer: filters PS/2 break codes, resolves the comma/n dead key,
// writes characters into the message RAM. Optional macro: TEXT_ENTRY_BACKSPACE_EN.
module text_entry_ctrl #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [7:0]  ENHE_CODE = 8'h4C
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  input  logic          msg_ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW:0]   msg_len,
  output logic          msg_done,
  output logic          enter,
  output logic          virgul
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_COMMA = 8'h41;
  localparam logic [7:0] CODE_N     = 8'h31;
`ifdef TEXT_ENTRY_BACKSPACE_EN
  localparam logic [7:0] CODE_BKSP  = 8'h66;
`endif
  localparam logic [AW:0] FULL_LEN  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    MOD,
    FLUSH,
    PEND,
    DONE
  } state_t;

  state_t     state;
  state_t     origin;
  logic [7:0] flush_byte;
  logic [7:0] hold_byte;
  logic       hold_valid;

  logic       in_valid;
  logic [7:0] in_byte;
  logic       full;

  // A byte queued during FLUSH takes priority over the live input on the next cycle.
  always_comb begin
    in_valid = hold_valid | key_valid;
    in_byte  = hold_valid ? hold_byte : key_code;
    full     = (msg_len == FULL_LEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      origin     <= IDLE;
      flush_byte <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      msg_len    <= '0;
      msg_done   <= 1'b0;
      enter      <= 1'b0;
      virgul     <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      // FLUSH does not consume input, so a live byte is parked; elsewhere the parked
      // byte is consumed and any simultaneous live byte takes its place.
      if (state == FLUSH) begin
        if (key_valid && !hold_valid) begin
          hold_valid <= 1'b1;
          hold_byte  <= key_code;
        end
      end else if (hold_valid) begin
        hold_valid <= key_valid;
        hold_byte  <= key_code;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            case (in_byte)
              CODE_BREAK: begin
                state  <= BRK;
                origin <= IDLE;
              end
              CODE_ENTER: begin
                state    <= DONE;
                enter    <= 1'b1;
                msg_done <= 1'b1;
                virgul   <= 1'b0;
              end
              CODE_COMMA: begin
                state  <= MOD;
                virgul <= 1'b1;
              end
`ifdef TEXT_ENTRY_BACKSPACE_EN
              CODE_BKSP: begin
                if (msg_len != '0) msg_len <= msg_len - ONE;
              end
`endif
              default: begin
                if (!full) begin
                  wr_en   <= 1'b1;
                  wr_addr <= msg_len[AW-1:0];
                  wr_data <= in_byte;
                  msg_len <= msg_len + ONE;
                end
              end
            endcase
          end
        end

        BRK: begin
          if (in_valid) state <= origin;
        end

        MOD: begin
          if (in_valid) begin
            case (in_byte)
              CODE_N: begin
                if (!full) begin
                  wr_en   <= 1'b1;
                  wr_addr <= msg_len[AW-1:0];
                  wr_data <= ENHE_CODE;
                  msg_len <= msg_len + ONE;
                end
                virgul <= 1'b0;
                state  <= IDLE;
              end
              CODE_BREAK: begin
                state  <= BRK;
                origin <= MOD;
              end
`ifdef TEXT_ENTRY_BACKSPACE_EN
              CODE_BKSP: begin
                virgul <= 1'b0;
                state  <= IDLE;
              end
`endif
              default: begin
                // Any non-n byte first commits the pending comma.
                if (!full) begin
                  wr_en   <= 1'b1;
                  wr_addr <= msg_len[AW-1:0];
                  wr_data <= CODE_COMMA;
                  msg_len <= msg_len + ONE;
                end
                if (in_byte == CODE_ENTER) begin
                  virgul <= 1'b0;
                  state  <= PEND;
                end else if (in_byte != CODE_COMMA) begin
                  virgul     <= 1'b0;
                  flush_byte <= in_byte;
                  state      <= FLUSH;
                end
              end
            endcase
          end
        end

        FLUSH: begin
          if (!full) begin
            wr_en   <= 1'b1;
            wr_addr <= msg_len[AW-1:0];
            wr_data <= flush_byte;
            msg_len <= msg_len + ONE;
          end
          state <= IDLE;
        end

        PEND: begin
          enter    <= 1'b1;
          msg_done <= 1'b1;
          virgul   <= 1'b0;
          state    <= DONE;
        end

        DONE: begin
          if (msg_ack) begin
            msg_len    <= '0;
            wr_addr    <= '0;
            enter      <= 1'b0;
            msg_done   <= 1'b0;
            hold_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Directed-vector bench for text_entry_ctrl; each vector is one clock of stimulus
// followed by the registered outputs expected after that edge.
module tb_text_entry_ctrl;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       msg_ack;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       msg_done;
  logic       enter;
  logic       virgul;

  text_entry_ctrl #(.DEPTH(16), .AW(4), .ENHE_CODE(8'h4C)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .msg_ack(msg_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .msg_done(msg_done), .enter(enter), .virgul(virgul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       kv;
    logic [7:0] code;
    logic       ack;
    logic       wen;
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] len;
    logic       done;
    logic       ent;
    logic       vir;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input logic kv, input logic [7:0] code, input logic ack,
                              input logic wen, input logic [3:0] addr, input logic [7:0] data,
                              input logic [4:0] len, input logic done, input logic ent,
                              input logic vir);
    vec_t v;
    v.kv = kv; v.code = code; v.ack = ack; v.wen = wen; v.addr = addr; v.data = data;
    v.len = len; v.done = done; v.ent = ent; v.vir = vir;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name, input vec_t e, input logic strict);
    logic bad;
    n_vec++;
    bad = (wr_en !== e.wen) || (msg_len !== e.len) || (msg_done !== e.done) ||
          (enter !== e.ent) || (virgul !== e.vir);
    if ((e.wen || strict) && ((wr_addr !== e.addr) || (wr_data !== e.data))) bad = 1'b1;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got wr_en=%0b addr=%0d data=%h len=%0d done=%0b enter=%0b virgul=%0b, want wr_en=%0b addr=%0d data=%h len=%0d done=%0b enter=%0b virgul=%0b",
               name, wr_en, wr_addr, wr_data, msg_len, msg_done, enter, virgul,
               e.wen, e.addr, e.data, e.len, e.done, e.ent, e.vir);
    end
  endtask

  // Drive one cycle of input (called just after a rising edge), check after the next edge.
  task automatic step(input string name, input logic kv, input logic [7:0] code, input logic ack,
                      input logic wen, input logic [3:0] addr, input logic [7:0] data,
                      input logic [4:0] len, input logic done, input logic ent, input logic vir);
    vec_t e;
    key_valid = kv; key_code = code; msg_ack = ack;
    @(posedge clk);
    #1;
    key_valid = 1'b0; msg_ack = 1'b0;
    e = '{kv: kv, code: code, ack: ack, wen: wen, addr: addr, data: data,
          len: len, done: done, ent: ent, vir: vir};
    check_out(name, e, 1'b0);
  endtask

  task automatic check_zero(input string name);
    vec_t z;
    z = '0;
    check_out(name, z, 1'b1);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = '0; msg_ack = 1'b0;

    // break pair filtered
    add(1, 8'h1C, 0, 1, 0, 8'h1C, 1, 0, 0, 0);
    add(1, 8'hF0, 0, 0, 0, 0,     1, 0, 0, 0);
    add(1, 8'h1C, 0, 0, 0, 0,     1, 0, 0, 0);
    add(1, 8'h32, 0, 1, 1, 8'h32, 2, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0,     2, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0,     2, 0, 0, 0);  // ack outside DONE ignored
    // comma + n -> enhe
    add(1, 8'h41, 0, 0, 0, 0,     2, 0, 0, 1);
    add(1, 8'h31, 0, 1, 2, 8'h4C, 3, 0, 0, 0);
    // comma + other, with a byte queued during FLUSH
    add(1, 8'h41, 0, 0, 0, 0,     3, 0, 0, 1);
    add(1, 8'h1C, 0, 1, 3, 8'h41, 4, 0, 0, 0);
    add(1, 8'h24, 0, 1, 4, 8'h1C, 5, 0, 0, 0);
    add(0, 8'h00, 0, 1, 5, 8'h24, 6, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0,     6, 0, 0, 0);
    // break inside MOD returns to MOD; double comma
    add(1, 8'h41, 0, 0, 0, 0,     6, 0, 0, 1);
    add(1, 8'hF0, 0, 0, 0, 0,     6, 0, 0, 1);
    add(1, 8'h31, 0, 0, 0, 0,     6, 0, 0, 1);
    add(1, 8'h41, 0, 1, 6, 8'h41, 7, 0, 0, 1);
    add(1, 8'h31, 0, 1, 7, 8'h4C, 8, 0, 0, 0);
    // fill to DEPTH
    for (int i = 0; i < 8; i++)
      add(1, 8'(8'h10 + i), 0, 1, 4'(8 + i), 8'(8'h10 + i), 5'(9 + i), 0, 0, 0);
    add(1, 8'h1A, 0, 0, 0, 0,     16, 0, 0, 0);  // 17th byte dropped
    add(1, 8'h41, 0, 0, 0, 0,     16, 0, 0, 1);
    add(1, 8'h31, 0, 0, 0, 0,     16, 0, 0, 0);  // enhe dropped when full
    add(1, 8'h41, 0, 0, 0, 0,     16, 0, 0, 1);
    add(1, 8'h1C, 0, 0, 0, 0,     16, 0, 0, 0);  // comma dropped
    add(0, 8'h00, 0, 0, 0, 0,     16, 0, 0, 0);  // flush dropped
    add(1, 8'h5A, 0, 0, 0, 0,     16, 1, 1, 0);
    add(1, 8'h1C, 0, 0, 0, 0,     16, 1, 1, 0);  // ignored in DONE
    add(0, 8'h00, 0, 0, 0, 0,     16, 1, 1, 0);
    add(1, 8'h32, 1, 0, 0, 0,     0,  0, 0, 0);  // ack wins over key
    add(0, 8'h00, 0, 0, 0, 0,     0,  0, 0, 0);
    // comma then Enter: comma written, Enter one cycle later
    add(1, 8'h41, 0, 0, 0, 0,     0,  0, 0, 1);
    add(1, 8'h5A, 0, 1, 0, 8'h41, 1,  0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0,     1,  1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0,     0,  0, 0, 0);
    add(1, 8'h1C, 0, 1, 0, 8'h1C, 1,  0, 0, 0);

    #12;
    check_zero("reset_state");
    reset = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      step($sformatf("vec%0d", i), v.kv, v.code, v.ack, v.wen, v.addr, v.data,
           v.len, v.done, v.ent, v.vir);
    end

    // asynchronous reset while a comma is pending
    step("mid_mod_comma", 1, 8'h41, 0, 0, 0, 0, 1, 0, 0, 1);
    #2 reset = 1'b1;
    #1 check_zero("async_reset_mod");
    #2 reset = 1'b0;
    step("post_reset_mod_a", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset_mod_b", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset during FLUSH abandons the latched byte
    step("flush_comma",  1, 8'h41, 0, 0, 0, 0,     0, 0, 0, 1);
    step("flush_commit", 1, 8'h1C, 0, 1, 0, 8'h41, 1, 0, 0, 0);
    reset = 1'b1;
    #1 check_zero("async_reset_flush");
    #2 reset = 1'b0;
    step("post_reset_flush_a", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset_flush_b", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef TEXT_ENTRY_BACKSPACE_EN
    step("bs_a",      1, 8'h1C, 0, 1, 0, 8'h1C, 1, 0, 0, 0);
    step("bs_b",      1, 8'h32, 0, 1, 1, 8'h32, 2, 0, 0, 0);
    step("bs_dec",    1, 8'h66, 0, 0, 0, 0,     1, 0, 0, 0);
    step("bs_dec0",   1, 8'h66, 0, 0, 0, 0,     0, 0, 0, 0);
    step("bs_at0",    1, 8'h66, 0, 0, 0, 0,     0, 0, 0, 0);
    step("bs_comma",  1, 8'h41, 0, 0, 0, 0,     0, 0, 0, 1);
    step("bs_cancel", 1, 8'h66, 0, 0, 0, 0,     0, 0, 0, 0);
    step("bs_after",  1, 8'h1C, 0, 1, 0, 8'h1C, 1, 0, 0, 0);
`else
    step("bs_print",  1, 8'h66, 0, 1, 0, 8'h66, 1, 0, 0, 0);
    step("bs_comma",  1, 8'h41, 0, 0, 0, 0,     1, 0, 0, 1);
    step("bs_flush",  1, 8'h66, 0, 1, 1, 8'h41, 2, 0, 0, 0);
    step("bs_flushd", 0, 8'h00, 0, 1, 2, 8'h66, 3, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
